// File: rtl/fb_pkg.sv
// Shared frame buffer constants and the reader FSM state encoding.
// The RAM, the writer and the reader all import this package so the
// geometry and address width agree everywhere.
package fb_pkg;

  localparam int SCREEN_WIDTH  = 176;
  localparam int SCREEN_HEIGHT = 120;
  localparam int FB_ADDR_W     = 15;
  localparam int FB_DATA_W     = 8;
  localparam int FB_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fb_state_e;

endpackage

// File: rtl/fb_stream_fifo.sv
// Synchronous FIFO with a registered head entry.
// The head lives in its own register so the stream outputs come straight
// from flops; the remaining DEPTH-1 entries sit in a small shift buffer
// behind it. Total capacity is DEPTH entries.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   wr_en/wr_data push one entry (caller guarantees space)
//   rd_en         consumer ready; pops the head when head_valid
//   head_valid    head register holds an entry
//   head_data     head entry
//   count         occupancy including the head
module fb_stream_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic                           head_valid,
  output logic [WIDTH-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int BACK_N = DEPTH - 1;
  localparam int BC_W   = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] back [BACK_N];
  logic [BC_W-1:0]  bc;
  logic             pop;
  logic             head_free;

  assign pop       = head_valid & rd_en;
  assign head_free = ~head_valid | pop;
  assign count     = CNT_W'(head_valid) + CNT_W'(bc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      bc         <= '0;
      for (int i = 0; i < BACK_N; i++) back[i] <= '0;
    end else if (head_free) begin
      if (bc != '0) begin
        // Refill the head from the buffer and shift the rest down; a
        // simultaneous write lands in the slot the shift just vacated.
        head_valid <= 1'b1;
        head_data  <= back[0];
        for (int i = 0; i < BACK_N - 1; i++) back[i] <= back[i+1];
        if (wr_en) back[bc - 1'b1] <= wr_data;
        else       bc <= bc - 1'b1;
      end else if (wr_en) begin
        head_valid <= 1'b1;
        head_data  <= wr_data;
      end else begin
        head_valid <= 1'b0;
      end
    end else if (wr_en) begin
      back[bc] <= wr_data;
      bc       <= bc + 1'b1;
    end
  end

endmodule

// File: rtl/frame_buffer_reader.sv
// Raster-order read engine for the frame buffer. Issues one read address
// per cycle while the output FIFO has room for everything in flight,
// tags each returning pixel with x/y and frame/line markers, and streams
// them out on a valid/ready interface.
//
// State table:
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_RUN   | issuing read addresses
//   ST_DRAIN | last address issued, emptying pipeline and FIFO
//   ST_DONE  | one-cycle frame_done pulse
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start              begin one frame (accepted only in ST_IDLE)
//   busy, frame_done   frame in progress / end-of-frame pulse
//   r_addr, r_data     buffer read port (1-cycle registered read)
//   pix_*              pixel stream: data, x, y, sof, eol, valid, ready
module frame_buffer_reader
  import fb_pkg::*;
#(
  parameter int WIDTH  = SCREEN_WIDTH,
  parameter int HEIGHT = SCREEN_HEIGHT,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int DEPTH  = FB_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  output logic [DATA_W-1:0] pix_data,
  output logic [7:0]        pix_x,
  output logic [6:0]        pix_y,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_valid,
  input  logic              pix_ready
);

  localparam int ENTRY_W = DATA_W + 8 + 7 + 2;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  fb_state_e          state;
  logic               rd_vld;    // r_addr carries a live read this cycle
  logic               data_vld;  // r_data carries a live pixel this cycle
  logic [7:0]         ix, dx;
  logic [6:0]         iy, dy;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     pend;
  logic               pop;
  logic               last_issue;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

  assign pop = pix_valid & pix_ready;

  // Entries that will be held or still owed to the FIFO after this edge,
  // before any new issue. Keeping this below DEPTH means every read can
  // always be absorbed, so the FIFO never overflows.
  assign pend = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(data_vld)
              + (CNT_W+1)'(rd_vld) - (CNT_W+1)'(pop);

  assign last_issue = rd_vld && (ix == 8'(WIDTH - 1)) && (iy == 7'(HEIGHT - 1));

  assign wr_entry = {r_data, dx, dy,
                     (dx == 8'd0) && (dy == 7'd0),
                     (dx == 8'(WIDTH - 1))};

  assign {pix_data, pix_x, pix_y, pix_sof, pix_eol} = head_entry;

  fb_stream_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (data_vld),
    .wr_data    (wr_entry),
    .rd_en      (pix_ready),
    .head_valid (pix_valid),
    .head_data  (head_entry),
    .count      (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      r_addr     <= '0;
      rd_vld     <= 1'b0;
      data_vld   <= 1'b0;
      ix         <= '0;
      iy         <= '0;
      dx         <= '0;
      dy         <= '0;
    end else begin
      frame_done <= 1'b0;
      // Coordinates follow the read through the RAM's one-cycle latency.
      data_vld   <= rd_vld;
      dx         <= ix;
      dy         <= iy;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_RUN;
            busy   <= 1'b1;
            r_addr <= '0;
            ix     <= '0;
            iy     <= '0;
            rd_vld <= 1'b1;
          end
        end
        ST_RUN: begin
          if (last_issue) begin
            state  <= ST_DRAIN;
            rd_vld <= 1'b0;
          end else if (pend < (CNT_W+1)'(DEPTH)) begin
            rd_vld <= 1'b1;
            r_addr <= r_addr + 1'b1;
            if (ix == 8'(WIDTH - 1)) begin
              ix <= '0;
              iy <= iy + 1'b1;
            end else begin
              ix <= ix + 1'b1;
            end
          end else begin
            rd_vld <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // pend already accounts for a pop this cycle, so DONE lands
          // in the cycle right after the final handshake.
          if (pend == '0) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_reader.sv
module tb_frame_buffer_reader;

  localparam int W     = 176;
  localparam int H     = 120;
  localparam int N     = W * H;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic [14:0] r_addr;
  logic [7:0]  r_data;
  logic [7:0]  pix_data;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_valid;
  logic        pix_ready;

  logic [7:0]  mem [N];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          got;
  bit          stall;
  bit          hs;
  logic [25:0] held;

  typedef struct {
    logic        ready;
    logic [14:0] r_addr;
    logic        valid;
    logic [7:0]  x;
  } row_t;

  row_t tbl [10];

  frame_buffer_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .r_addr     (r_addr),
    .r_data     (r_data),
    .pix_data   (pix_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural buffer read port: one-cycle registered read.
  always @(posedge clk) r_data <= mem[r_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fill_mem(input bit rnd);
    for (int a = 0; a < N; a++) mem[a] = rnd ? 8'($urandom) : 8'(a);
  endtask

  // Reference pixel n: raster order, coordinates from plain division.
  function automatic logic [24:0] exp_pix(input int n);
    logic [7:0] x;
    logic [6:0] y;
    x = 8'(n % W);
    y = 7'(n / W);
    return {mem[n], x, y, (n == 0), (n % W == W - 1)};
  endfunction

  function automatic logic [25:0] cur_out();
    return {pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol};
  endfunction

  function automatic logic [42:0] all_outs();
    return {busy, frame_done, r_addr, pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol};
  endfunction

  // Called once per cycle at the negedge: stall stability, ready draw,
  // and comparison of any pixel that will handshake at the next edge.
  task automatic cycle_check(input int pct, input int base);
    logic r;
    int   n;
    if (stall) check("stall_stable", 64'(cur_out()), 64'(held));
    r = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
    pix_ready = r;
    hs = pix_valid && r;
    if (hs) begin
      n = base + got;
      check("pixel_in_range", 64'(n < N), 64'(1));
      if (n < N)
        check("pixel", 64'({pix_data, pix_x, pix_y, pix_sof, pix_eol}), 64'(exp_pix(n)));
      got++;
    end
    stall = pix_valid && !r;
    held  = cur_out();
  endtask

  task automatic take_pixels(input int base, input int n, input int pct);
    int cyc = 0;
    got = 0;
    while (got < n && cyc < n * 8 + 100) begin
      @(negedge clk);
      cyc++;
      cycle_check(pct, base);
    end
    check("take_count", 64'(got), 64'(n));
  endtask

  // Runs one frame whose start was sampled at the edge before the first
  // negedge here. poke: stray start mid-frame. chain: start held through
  // DONE and the following cycle, so the next frame begins right away.
  task automatic run_frame(input int pct, input bit poke, input bit chain);
    int cyc      = 0;
    int done_cnt = 0;
    int last_hs  = -100;
    int d_cyc    = -1;
    got   = 0;
    stall = 0;
    forever begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        check("busy_after_start", 64'(busy), 64'(1));
        check("first_r_addr", 64'(r_addr), 64'(0));
      end
      if (cyc == 2) check("valid_cycle2", 64'(pix_valid), 64'(0));
      if (cyc == 3) check("valid_cycle3", 64'(pix_valid), 64'(1));
      if (frame_done) begin
        done_cnt++;
        d_cyc = cyc;
        check("done_latency", 64'(cyc), 64'(last_hs + 1));
        check("busy_in_done", 64'(busy), 64'(0));
      end
      if (busy) check("addr_ahead", 64'((int'(r_addr) + 1 - got) <= DEPTH), 64'(1));
      cycle_check(pct, 0);
      if (hs) last_hs = cyc;
      if (poke && cyc == 1000) start = 1'b1;
      if (d_cyc > 0) begin
        if (chain) begin
          if (cyc == d_cyc) begin
            start = 1'b1;
          end else begin
            check("start_in_done_ignored", 64'(busy), 64'(0));
            start = 1'b1;
            fill_mem(1);
            break;
          end
        end else if (cyc >= d_cyc + 3) begin
          break;
        end
      end
      if (cyc > 60000) begin
        check("frame_timeout", 64'(cyc), 64'(60000));
        break;
      end
    end
    check("frame_pixels", 64'(got), 64'(N));
    check("frame_done_count", 64'(done_cnt), 64'(1));
  endtask

  initial begin
    // Stall-after-start vectors: ready applied after each row's check.
    tbl[0] = '{1'b0, 15'd0, 1'b0, 8'd0};
    tbl[1] = '{1'b0, 15'd1, 1'b0, 8'd0};
    tbl[2] = '{1'b0, 15'd2, 1'b1, 8'd0};
    tbl[3] = '{1'b0, 15'd3, 1'b1, 8'd0};
    tbl[4] = '{1'b0, 15'd3, 1'b1, 8'd0};
    tbl[5] = '{1'b1, 15'd3, 1'b1, 8'd0};
    tbl[6] = '{1'b1, 15'd4, 1'b1, 8'd1};
    tbl[7] = '{1'b1, 15'd5, 1'b1, 8'd2};
    tbl[8] = '{1'b1, 15'd6, 1'b1, 8'd3};
    tbl[9] = '{1'b1, 15'd7, 1'b1, 8'd4};

    rst_n     = 1'b0;
    start     = 1'b0;
    pix_ready = 1'b0;
    got       = 0;
    stall     = 0;
    hs        = 0;
    held      = '0;
    fill_mem(0);

    repeat (3) @(negedge clk);
    check("reset_state", 64'(all_outs()), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 64'({busy, pix_valid, frame_done}), 64'(0));

    // Frame A: ready high, stray starts mid-frame and in DONE, chained
    // start right after DONE into frame B with random data and ready.
    start = 1'b1;
    run_frame(100, 1'b1, 1'b1);
    run_frame(50, 1'b0, 1'b0);

    // Stall after start, release, then reset while pixel 5000 is at the head.
    fill_mem(0);
    @(negedge clk);
    start     = 1'b1;
    pix_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("tbl_r_addr", 64'(r_addr), 64'(tbl[i].r_addr));
      check("tbl_valid", 64'(pix_valid), 64'(tbl[i].valid));
      if (tbl[i].valid)
        check("tbl_pixel", 64'({pix_data, pix_x, pix_y, pix_sof}),
              64'({tbl[i].x, tbl[i].x, 7'd0, tbl[i].x == 8'd0}));
      pix_ready = tbl[i].ready;
    end
    stall = 0;
    take_pixels(5, 4995, 100);
    @(negedge clk);
    check("pixel_5000_head", 64'(cur_out()), 64'({1'b1, exp_pix(5000)}));
    rst_n     = 1'b0;
    pix_ready = 1'b0;
    @(negedge clk);
    check("midframe_reset_outputs", 64'(all_outs()), 64'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stray_after_reset", 64'({busy, pix_valid, frame_done}), 64'(0));
    end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stall = 0;
    take_pixels(0, 40, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
